bitreverse_buffer: RTL and testbench
====================================

// Module: bitreverse_buffer
// PURPOSE
//  Output reorder buffer directly downstream of the final radix-2 butterfly stage.
//  Takes the two-sample-per-clock, bit-reversed-order stream and re-emits it in
//  natural bin order, two bins per clock (o_left = bin 2m, o_right = bin 2m+1).
//  Uses ping-pong frame banks, so streaming runs continuously at full rate.
// PARAMETERS
//  LGSIZE  12   log2(FFT size N); N = 4096
//  DW      34   width of one complex sample {re,im} (2 x 17-bit final stage output)
// PORTS
//  i_clk         in   1   clock
//  i_reset_n     in   1   asynchronous, active-low reset
//  i_clk_enable  in   1   global advance; when low all state and outputs hold
//  i_sync        in   1   high with input pair n=0 of a frame
//  i_left        in   DW  input pair n, bin rev(2n)   (rev = LGSIZE-bit reversal)
//  i_right       in   DW  input pair n, bin rev(2n+1)
//  o_left        out  DW  output pair m, bin 2m
//  o_right       out  DW  output pair m, bin 2m+1
//  o_sync        out  1   high with output pair m=0 of a frame
// BEHAVIOUR
//  - All activity advances only on edges with i_clk_enable=1 ("enabled edges").
//  - Reset (async assert, sync release): write count, read count, bank select,
//    primed flag = 0; o_left=o_right=0, o_sync=0. RAM contents are not reset.
//  - Write side: idle until first i_sync. i_sync edge writes pair n=0; n then
//    increments every enabled edge, wraps N/2-1 -> 0 and toggles write bank.
//    Input is continuous after the first sync; no gaps besides clock enable.
//  - i_sync with n!=0 (misaligned): restart at n=0 in same bank; partial frame
//    discarded; read side continues unaffected. i_sync at wrap (n=N/2-1 -> 0) is
//    the normal case and causes no disturbance.
//  - Storage: four RAMs of 2*(N/4) words, indexed {bank, a}. Input pair n goes to
//    L_lo/R_lo when n<N/4, L_hi/R_hi otherwise, at a = n mod N/4.
//  - Read side: on completion of a frame (wrap), primed=1 and reading of the
//    just-filled bank starts at m=0; m increments every enabled edge, wrapping at N/2.
//    For pair m: j = rev(2m); a = (j>>1) mod N/4; if j even read (L_lo[a], L_hi[a])
//    else (R_lo[a], R_hi[a]) -> (o_left, o_right). Conflict-free: one read per RAM.
//  - Latency: o_sync=1 exactly N/2+2 enabled edges after the edge sampling i_sync
//    of that frame (N/2 fill, 1 RAM read, 1 output register). o_sync is a 1-cycle
//    pulse per frame; output pairs are valid on every enabled cycle after.
//  - Before first frame completes: o_left=o_right=0, o_sync=0.
//  - Bank hazard: read bank is always the opposite of write bank, as both
//    counters advance in lockstep; a misaligned resync only touches the write bank.
//  - Data is passed bit-exact; no arithmetic, no rounding.
// STRUCTURE
//  - fft_pkg: LGSIZE default, function bitrev(value, width), sample typedef.
//  - Sub-module bitrev_sdpram: simple dual-port RAM, one write port, registered
//    read port, clock-enable gated; instantiated 4x (L_lo, L_hi, R_lo, R_hi).
//  - Top: write counter/bank FSM (IDLE -> FILL), read counter with primed flag,
//    address reversal, output mux and output register.
// TESTING (LGSIZE=4, N=16, data value = bin index)
//  1 Ramp frame: pairs (0,8),(4,12),(2,10),(6,14),(1,9),(5,13),(3,11),(7,15), i_sync
//    on first -> 10 enabled edges later o_sync=1, outputs (0,1),(2,3)...(14,15).
//  2 Three back-to-back frames with offsets 0/100/200 -> uninterrupted output,
//    o_sync every 8 cycles, frame k data = k*100 + bin, no inter-frame corruption.
//  3 i_clk_enable toggled randomly (~50%) during scenario 2 -> identical output
//    sequence when sampled on enabled edges only; outputs held when enable low.
//  4 i_sync re-asserted at n=3 in frame 2 -> partial frame discarded, frame 1
//    output intact, next o_sync 10 enabled edges after the re-sync.
//  5 i_reset_n asserted mid-read (no clock edge) -> outputs/o_sync 0 immediately;
//    after release no o_sync until a new full frame following i_sync.
//  6 Random data, LGSIZE=12, 4 frames -> scoreboard vs software bit-reversal model.

Source files
------------

// File: rtl/fft_pkg.sv
// Shared types and helpers for the FFT output reorder path.
package fft_pkg;

    localparam int unsigned LGSIZE_DEF = 12;

    // One complex output sample of the final butterfly stage.
    typedef struct packed {
        logic signed [16:0] re;
        logic signed [16:0] im;
    } sample_t;

    localparam int unsigned DW_DEF = $bits(sample_t);

    typedef enum logic {StIdle, StFill} wr_state_e;

    // Reverses the low `width` bits of value; value must be zero above width.
    function automatic logic [31:0] bitrev(input logic [31:0] value, input int unsigned width);
        logic [31:0] full;
        full = {<<{value}};
        return full >> (32 - width);
    endfunction

endpackage

// File: rtl/bitrev_sdpram.sv
// Simple dual-port RAM: one write port, one registered read port, clock-enable gated.
module bitrev_sdpram #(
    parameter int unsigned AW = 3,
    parameter int unsigned DW = 34
) (
    input  logic          i_clk,
    input  logic          i_ce,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [DW-1:0] i_wdata,
    input  logic [AW-1:0] i_raddr,
    output logic [DW-1:0] o_rdata
);

    logic [DW-1:0] r_mem [2**AW];
    logic [DW-1:0] r_rdata;

    // Write and registered read; a same-address read returns the old contents.
    always_ff @(posedge i_clk) begin
        if (i_ce) begin
            if (i_we) begin
                r_mem[i_waddr] <= i_wdata;
            end
            r_rdata <= r_mem[i_raddr];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/bitreverse_buffer.sv
// Reorders a bit-reversed two-sample-per-clock FFT stream into natural bin order
// using ping-pong frame banks split over four RAMs (L_lo, L_hi, R_lo, R_hi).
module bitreverse_buffer
    import fft_pkg::*;
#(
    parameter int unsigned LGSIZE = LGSIZE_DEF,
    parameter int unsigned DW     = DW_DEF
) (
    input  logic          i_clk,
    input  logic          i_reset_n,
    input  logic          i_clk_enable,
    input  logic          i_sync,
    input  logic [DW-1:0] i_left,
    input  logic [DW-1:0] i_right,
    output logic [DW-1:0] o_left,
    output logic [DW-1:0] o_right,
    output logic          o_sync
);

    localparam int unsigned CW = LGSIZE - 1;  // pair counter width (N/2 pairs)
    localparam int unsigned AW = LGSIZE - 2;  // per-bank RAM address (N/4 words)
    localparam logic [CW-1:0] LastPair = '1;

    // Write side
    wr_state_e     r_state, w_state_next;
    logic [CW-1:0] r_wcnt, w_wcnt_next, w_n;
    logic          r_wbank, w_wbank_next;
    logic          w_wr_en, w_wrap, w_hi;
    logic [AW:0]   w_waddr;

    // Read side
    logic          r_primed, r_rstart;
    logic [CW-1:0] r_rcnt, w_j;
    logic [AW:0]   r_raddr;
    logic          r_rodd1, r_rsync1, r_rvalid1;
    logic          r_rodd2, r_rsync2, r_rvalid2;
    logic [DW-1:0] w_llo, w_lhi, w_rlo, w_rhi;
    logic [DW-1:0] r_oleft, r_oright;
    logic          r_osync;

    // Write counter/bank next state; a sync always forces the current pair to n=0.
    always_comb begin
        w_state_next = r_state;
        w_wcnt_next  = r_wcnt;
        w_wbank_next = r_wbank;
        w_wr_en      = 1'b0;
        w_wrap       = 1'b0;
        w_n          = i_sync ? '0 : r_wcnt;
        if (r_state == StFill || i_sync) begin
            w_wr_en      = 1'b1;
            w_state_next = StFill;
            if (w_n == LastPair) begin
                w_wrap       = 1'b1;
                w_wcnt_next  = '0;
                w_wbank_next = ~r_wbank;
            end else begin
                w_wcnt_next = w_n + CW'(1);
            end
        end
    end

    assign w_hi    = w_n[CW-1];
    assign w_waddr = {r_wbank, w_n[AW-1:0]};

    // Write-side state register.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state <= StIdle;
            r_wcnt  <= '0;
            r_wbank <= 1'b0;
        end else if (i_clk_enable) begin
            r_state <= w_state_next;
            r_wcnt  <= w_wcnt_next;
            r_wbank <= w_wbank_next;
        end
    end

    // rev_L(2m) == rev_(L-1)(m) with a zero MSB, so the narrower reversal suffices.
    assign w_j = CW'(bitrev(32'(r_rcnt), CW));

    // Read counter restarts on every frame completion; address/valid pipeline behind it.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_primed  <= 1'b0;
            r_rstart  <= 1'b0;
            r_rcnt    <= '0;
            r_raddr   <= '0;
            r_rodd1   <= 1'b0;
            r_rsync1  <= 1'b0;
            r_rvalid1 <= 1'b0;
            r_rodd2   <= 1'b0;
            r_rsync2  <= 1'b0;
            r_rvalid2 <= 1'b0;
        end else if (i_clk_enable) begin
            if (w_wrap) begin
                r_primed <= 1'b1;
                r_rstart <= 1'b1;
                r_rcnt   <= '0;
            end else if (r_primed) begin
                r_rstart <= 1'b0;
                r_rcnt   <= r_rcnt + CW'(1);
            end
            // Reading always targets the bank not being written.
            r_raddr   <= {~r_wbank, w_j[AW:1]};
            r_rodd1   <= w_j[0];
            r_rsync1  <= r_rstart;
            r_rvalid1 <= r_primed;
            r_rodd2   <= r_rodd1;
            r_rsync2  <= r_rsync1;
            r_rvalid2 <= r_rvalid1;
        end
    end

    bitrev_sdpram #(.AW(AW + 1), .DW(DW)) u_l_lo (
        .i_clk   (i_clk),
        .i_ce    (i_clk_enable),
        .i_we    (w_wr_en & ~w_hi),
        .i_waddr (w_waddr),
        .i_wdata (i_left),
        .i_raddr (r_raddr),
        .o_rdata (w_llo)
    );

    bitrev_sdpram #(.AW(AW + 1), .DW(DW)) u_l_hi (
        .i_clk   (i_clk),
        .i_ce    (i_clk_enable),
        .i_we    (w_wr_en & w_hi),
        .i_waddr (w_waddr),
        .i_wdata (i_left),
        .i_raddr (r_raddr),
        .o_rdata (w_lhi)
    );

    bitrev_sdpram #(.AW(AW + 1), .DW(DW)) u_r_lo (
        .i_clk   (i_clk),
        .i_ce    (i_clk_enable),
        .i_we    (w_wr_en & ~w_hi),
        .i_waddr (w_waddr),
        .i_wdata (i_right),
        .i_raddr (r_raddr),
        .o_rdata (w_rlo)
    );

    bitrev_sdpram #(.AW(AW + 1), .DW(DW)) u_r_hi (
        .i_clk   (i_clk),
        .i_ce    (i_clk_enable),
        .i_we    (w_wr_en & w_hi),
        .i_waddr (w_waddr),
        .i_wdata (i_right),
        .i_raddr (r_raddr),
        .o_rdata (w_rhi)
    );

    // Output mux and register; zeros until the first frame has been read.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_oleft  <= '0;
            r_oright <= '0;
            r_osync  <= 1'b0;
        end else if (i_clk_enable) begin
            if (r_rvalid2) begin
                r_oleft  <= r_rodd2 ? w_rlo : w_llo;
                r_oright <= r_rodd2 ? w_rhi : w_lhi;
                r_osync  <= r_rsync2;
            end else begin
                r_oleft  <= '0;
                r_oright <= '0;
                r_osync  <= 1'b0;
            end
        end
    end

    assign o_left  = r_oleft;
    assign o_right = r_oright;
    assign o_sync  = r_osync;

endmodule

// File: tb/tb_bitreverse_buffer.sv
// Bench for bitreverse_buffer: a small (N=16) and a large (N=4096) instance, exercised
// one at a time through shared stimulus, model and scoreboard.
module tb_bitreverse_buffer;

    localparam int DW       = 34;
    localparam int LG_SMALL = 4;
    localparam int LG_BIG   = 12;
    localparam int NMAX     = 1 << LG_BIG;

    localparam int MZero    = 0;
    localparam int MFrame   = 1;
    localparam int MUnknown = 2;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          sel = 1'b0;
    logic          tb_en = 1'b0;
    logic          tb_sync = 1'b0;
    logic [DW-1:0] tb_l = '0;
    logic [DW-1:0] tb_r = '0;

    logic          en_s, en_b, s_sync, b_sync, mon_s;
    logic [DW-1:0] s_l, s_r, b_l, b_r, mon_l, mon_r;

    assign en_s  = tb_en & ~sel;
    assign en_b  = tb_en & sel;
    assign mon_l = sel ? b_l : s_l;
    assign mon_r = sel ? b_r : s_r;
    assign mon_s = sel ? b_sync : s_sync;

    always #5 clk = ~clk;

    bitreverse_buffer #(.LGSIZE(LG_SMALL), .DW(DW)) u_dut_small (
        .i_clk        (clk),
        .i_reset_n    (rst_n),
        .i_clk_enable (en_s),
        .i_sync       (tb_sync),
        .i_left       (tb_l),
        .i_right      (tb_r),
        .o_left       (s_l),
        .o_right      (s_r),
        .o_sync       (s_sync)
    );

    bitreverse_buffer #(.LGSIZE(LG_BIG), .DW(DW)) u_dut_big (
        .i_clk        (clk),
        .i_reset_n    (rst_n),
        .i_clk_enable (en_b),
        .i_sync       (tb_sync),
        .i_left       (tb_l),
        .i_right      (tb_r),
        .o_left       (b_l),
        .o_right      (b_r),
        .o_sync       (b_sync)
    );

    int checks = 0;
    int failures = 0;
    int lg, half, nfull;
    int ecnt = 0;

    // Scoreboard: expected o_sync edge per frame, and expected samples in natural order.
    int            sync_q[$];
    logic [DW-1:0] data_q[$];

    // Reference model state: which pair of the current frame comes next.
    bit            m_active = 1'b0;
    int            m_n = 0;
    int            m_start = 0;
    logic [DW-1:0] m_buf [NMAX];

    function automatic int rev(input int v, input int bits);
        int r = 0;
        for (int i = 0; i < bits; i++) begin
            r = r | (((v >> i) & 1) << (bits - 1 - i));
        end
        return r;
    endfunction

    function automatic logic [DW-1:0] rnd();
        return DW'({$urandom(), $urandom()});
    endfunction

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // One pair accepted on an enabled edge: place its two bins, emit a frame when full.
    function automatic void model_pair(input bit sync, input logic [DW-1:0] l,
                                       input logic [DW-1:0] r);
        if (sync) begin
            m_active = 1'b1;
            m_n      = 0;
        end
        if (m_active) begin
            if (m_n == 0) m_start = ecnt;
            m_buf[rev(2 * m_n, lg)]     = l;
            m_buf[rev(2 * m_n + 1, lg)] = r;
            if (m_n == half - 1) begin
                sync_q.push_back(m_start + half + 2);
                for (int b = 0; b < nfull; b++) data_q.push_back(m_buf[b]);
                m_n = 0;
            end else begin
                m_n++;
            end
        end
    endfunction

    function automatic void model_reset();
        m_active = 1'b0;
        m_n      = 0;
        sync_q.delete();
        data_q.delete();
    endfunction

    // Enabled-edge counter shared by model and monitor.
    always @(posedge clk) begin
        if (tb_en && rst_n) ecnt++;
    end

    // Monitor: tracks what the outputs must show and compares every cycle.
    int            mode = MZero;
    int            rem = 0;
    logic [DW-1:0] exp_l = '0;
    logic [DW-1:0] exp_r = '0;
    logic          exp_s = 1'b0;
    bit            en_now;

    always @(posedge clk) begin
        en_now = tb_en && rst_n;
        #1;
        if (!rst_n) begin
            mode  = MZero;
            rem   = 0;
            exp_l = '0;
            exp_r = '0;
            exp_s = 1'b0;
        end else begin
            if (en_now) begin
                if (sync_q.size() != 0 && sync_q[0] == ecnt) begin
                    void'(sync_q.pop_front());
                    exp_s = 1'b1;
                    mode  = MFrame;
                    rem   = half;
                end else begin
                    exp_s = 1'b0;
                end
                if (mode == MFrame) begin
                    if (rem > 0 && data_q.size() >= 2) begin
                        exp_l = data_q.pop_front();
                        exp_r = data_q.pop_front();
                        rem--;
                    end else begin
                        mode = MUnknown;
                    end
                end
            end
            check("o_sync", DW'(mon_s), DW'(exp_s));
            if (mode != MUnknown) begin
                check("o_left", mon_l, exp_l);
                check("o_right", mon_r, exp_r);
            end
        end
    end

    task automatic drive(input bit en, input bit sync, input logic [DW-1:0] l,
                         input logic [DW-1:0] r);
        tb_en   = en;
        tb_sync = sync;
        tb_l    = l;
        tb_r    = r;
        @(posedge clk);
        #1;
        if (en) model_pair(sync, l, r);
        @(negedge clk);
    endtask

    task automatic idle(input int cycles);
        for (int i = 0; i < cycles; i++) drive(1'b1, 1'b0, rnd(), rnd());
    endtask

    // Sends the first `cut` pairs of a frame; disabled cycles carry random junk and sync.
    task automatic send_frame(input int base, input bit rnd_data, input int cut,
                              input int en_pct);
        logic [DW-1:0] vals [NMAX];
        for (int b = 0; b < nfull; b++) vals[b] = rnd_data ? rnd() : DW'(base + b);
        for (int n = 0; n < cut; n++) begin
            while (int'($urandom_range(99)) >= en_pct) begin
                drive(1'b0, 1'($urandom_range(1)), rnd(), rnd());
            end
            drive(1'b1, n == 0, vals[rev(2 * n, lg)], vals[rev(2 * n + 1, lg)]);
        end
    endtask

    task automatic set_size(input int l);
        lg    = l;
        half  = 1 << (l - 1);
        nfull = 1 << l;
    endtask

    initial begin
        set_size(LG_SMALL);
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_left", mon_l, '0);
        check("reset_right", mon_r, '0);
        check("reset_sync", DW'(mon_s), '0);
        rst_n = 1'b1;
        idle(5);

        // Ramp frame followed by back-to-back frames at offsets 100 and 200.
        send_frame(0, 1'b0, half, 100);
        send_frame(100, 1'b0, half, 100);
        send_frame(200, 1'b0, half, 100);

        // Same three frames with roughly half the edges disabled.
        send_frame(0, 1'b0, half, 50);
        send_frame(100, 1'b0, half, 50);
        send_frame(200, 1'b0, half, 50);

        // Misaligned resync three pairs into a frame.
        send_frame(300, 1'b0, half, 100);
        send_frame(400, 1'b0, 3, 100);
        send_frame(500, 1'b0, half, 100);
        idle(4);

        // Asynchronous reset in the middle of reading frame 500.
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_left", mon_l, '0);
        check("async_rst_right", mon_r, '0);
        check("async_rst_sync", DW'(mon_s), '0);
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        idle(3 * half);
        send_frame(600, 1'b0, half, 100);
        idle(half + 4);

        // Full-size instance: four frames of random data.
        rst_n = 1'b0;
        model_reset();
        sel = 1'b1;
        set_size(LG_BIG);
        @(negedge clk);
        @(negedge clk);
        check("big_reset_left", mon_l, '0);
        check("big_reset_sync", DW'(mon_s), '0);
        rst_n = 1'b1;
        idle(3);
        repeat (4) send_frame(0, 1'b1, half, 100);
        idle(half + 4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
